pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Replaces fixed-width enable/clear stage registers (F->D, D->E, E->M, M->W) in the 5-stage CPU.
//  Registered ready breaks the stall combinational path; flush squashes wrong-path payloads.
//  Empty output presents NOP_VAL, so an empty stage is a bubble.
// PARAMETERS
//  DATA_W  64     payload width, e.g. {pc[31:0], instr[31:0]}
//  SIDE_W  1      sideband width (branch-predict flag, exception code); flushed with payload
//  NOP_VAL '0     payload driven on out_data while out_valid=0
//  CNT_W   16     perf counter width; only used with PIPE_STAGE_PERF_EN
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  flush      in   1       squash all held entries, synchronous
//  in_valid   in   1       upstream payload valid
//  in_ready   out  1       stage can accept; registered
//  in_data    in   DATA_W  upstream payload
//  in_side    in   SIDE_W  upstream sideband
//  out_valid  out  1       payload valid toward downstream
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_data   out  DATA_W  head payload, or NOP_VAL when empty
//  out_side   out  SIDE_W  head sideband, or 0 when empty
//  stall_cnt  out  CNT_W   [PIPE_STAGE_PERF_EN] cycles with out_valid & ~out_ready
//  flush_cnt  out  CNT_W   [PIPE_STAGE_PERF_EN] flushes that squashed >=1 valid entry
// BEHAVIOUR
//  - Storage: main entry (head, drives out_*) and skid entry. States: EMPTY, ONE, TWO.
//  - Reset (async): state EMPTY; in_ready=1; out_valid=0; out_data=NOP_VAL; out_side=0; counters 0.
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready. All updates on posedge clk.
//  - EMPTY: accept -> ONE (main<=in). Latency in->out is exactly 1 cycle.
//  - ONE: accept&pop -> ONE (main<=in). accept&~pop -> TWO (skid<=in).
//    ~accept&pop -> EMPTY. Otherwise hold.
//  - TWO: in_ready=0, so no accept. pop -> ONE (main<=skid). ~pop -> hold.
//  - in_ready is registered: next in_ready = (next_state != TWO). No comb path out_ready->in_ready.
//  - Order preserved; no payload is duplicated or dropped except by flush.
//  - flush has priority over everything:
//    - next state EMPTY; both entries invalidated; next out_data=NOP_VAL; next in_ready=1.
//    - In the flush cycle, an accept handshake still completes (in_ready is honoured) but its
//      payload is discarded. A pop in the flush cycle still counts as consumed downstream.
//  - flush while stalled (out_ready=0) still squashes.
//  - Invalid entries hold stale data internally; outputs are masked to NOP_VAL/0.
//  - Reset mid-stream: immediate return to reset values, regardless of clk.
// CONFIGURATION
//  - PIPE_STAGE_PERF_EN defined:
//    - stall_cnt and flush_cnt exist; both saturate at all-ones.
//    - Both reset to 0. A flush of an EMPTY stage does not increment flush_cnt.
//  - PIPE_STAGE_PERF_EN undefined:
//    - ports stall_cnt and flush_cnt and their logic are absent; CNT_W is unused.
//    - Datapath behaviour is identical in both builds.
// STRUCTURE
//  - Package pipe_pkg: state enum pipe_state_e {EMPTY, ONE, TWO}; localparam NOP_INSTR=32'h0;
//    default stage widths FD_W, DE_W, EM_W, MW_W.
//  - Sub-module pipe_sat_cnt (CNT_W, inc, async reset): instantiated twice under PIPE_STAGE_PERF_EN.
//  - Control FSM and the two data entries stay in this module.
// TESTING
//  - Reset: assert reset mid-TWO -> same cycle out_valid=0, out_data=NOP_VAL, in_ready=1.
//  - Streaming: out_ready=1, push 0x1..0x8 back-to-back ->
//    out_data 0x1..0x8 on consecutive cycles, each 1 cycle after its accept; in_ready stays 1.
//  - Stall/skid: push 0xA,0xB with out_ready=0 -> state TWO, in_ready=0 next cycle,
//    out_data holds 0xA. Release -> 0xA then 0xB; 0xC offered during the stall is not lost.
//  - Flush: in TWO (0xA,0xB) with flush=1, in_valid=1 (0xC) ->
//    next cycle out_valid=0, out_data=NOP_VAL, in_ready=1; 0xC never appears.
//  - Flush when EMPTY: no effect on outputs; flush_cnt unchanged (PERF build).
//  - Perf: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5.
//    With CNT_W=2, 10 cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and default stage widths for the pipeline stage buffers.
// Latency: n/a. Backpressure: n/a.
// Config: none.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Default payload widths of the four CPU stage boundaries
    localparam int FD_W = 64;
    localparam int DE_W = 160;
    localparam int EM_W = 104;
    localparam int MW_W = 72;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream bundle carrying a payload plus sideband.
// Latency: n/a. Backpressure: ready is driven by the slave side.
// Config: none.
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = FD_W,
    parameter int SIDE_W = 1
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [SIDE_W-1:0] side;

    modport master (output valid, output data, output side, input ready);
    modport slave  (input valid, input data, input side, output ready);
endinterface

// File: rtl/pipe_stage_buf_sat_cnt.sv
// Saturating event counter; sticks at all-ones.
// Latency: count visible 1 cycle after inc. Backpressure: none.
// Config: none.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with 2-entry skid buffer, flush, NOP-masked output.
// Latency: 1 cycle in->out. Backpressure: registered in_ready drops only when both entries are full.
// Config: PIPE_STAGE_PERF_EN adds saturating stall_cnt / flush_cnt.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = FD_W,
    parameter int                SIDE_W  = 1,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSTR),
    parameter int                CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_buf_if.slave  up,
    pipe_stage_buf_if.master dn
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_e       state_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_dat;
    logic [DATA_W-1:0] skid_dat;
    logic [SIDE_W-1:0] main_side;
    logic [SIDE_W-1:0] skid_side;
    logic              out_valid;
    logic              accept;
    logic              pop;

    assign out_valid = (state_q != EMPTY);
    assign accept    = up.valid & in_ready_q;
    assign pop       = out_valid & dn.ready;

    assign up.ready = in_ready_q;
    assign dn.valid = out_valid;
    assign dn.data  = out_valid ? main_dat : NOP_VAL;
    assign dn.side  = out_valid ? main_side : '0;

    // in_ready_q is kept equal to (state_q != TWO) so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_dat   <= NOP_VAL;
            skid_dat   <= NOP_VAL;
            main_side  <= '0;
            skid_side  <= '0;
        end else if (flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_dat  <= up.data;
                        main_side <= up.side;
                        state_q   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_dat  <= up.data;
                        main_side <= up.side;
                    end else if (accept) begin
                        skid_dat   <= up.data;
                        skid_side  <= up.side;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_dat   <= skid_dat;
                        main_side  <= skid_side;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~dn.ready),
        .cnt   (stall_cnt)
    );

    // Only flushes that actually squash a held entry are counted
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & out_valid),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed-vector bench for pipe_stage_buf: streaming, skid, flush, async reset, perf counters.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int         DW  = 64;
    localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    typedef struct {
        bit          fl;
        bit          iv;
        logic [63:0] d;
        bit          ordy;
        bit          ev;
        logic [63:0] ed;
        bit          erdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    pipe_stage_buf_if #(.DATA_W(DW), .SIDE_W(1)) up_if ();
    pipe_stage_buf_if #(.DATA_W(DW), .SIDE_W(1)) dn_if ();

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  stall_cnt2;
    logic [1:0]  flush_cnt2;
    pipe_stage_buf_if #(.DATA_W(DW), .SIDE_W(1)) up2_if ();
    pipe_stage_buf_if #(.DATA_W(DW), .SIDE_W(1)) dn2_if ();
    assign up2_if.valid = up_if.valid;
    assign up2_if.data  = up_if.data;
    assign up2_if.side  = up_if.side;
    assign dn2_if.ready = dn_if.ready;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .SIDE_W(1), .NOP_VAL(NOP), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (rst),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_buf #(.DATA_W(DW), .SIDE_W(1), .NOP_VAL(NOP), .CNT_W(2)) dut2 (
        .clk       (clk),
        .reset     (rst),
        .flush     (flush),
        .up        (up2_if),
        .dn        (dn2_if),
        .stall_cnt (stall_cnt2),
        .flush_cnt (flush_cnt2)
    );
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit fl, input bit iv, input logic [63:0] d, input bit ordy);
        flush        = fl;
        up_if.valid  = iv;
        up_if.data   = d;
        up_if.side   = d[0];
        dn_if.ready  = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input bit ev, input logic [63:0] ed, input bit erdy);
        chk({tag, " out_valid"}, 64'(dn_if.valid), 64'(ev));
        chk({tag, " out_data"},  dn_if.data, ev ? ed : NOP);
        chk({tag, " out_side"},  64'(dn_if.side), ev ? 64'(ed[0]) : 64'd0);
        chk({tag, " in_ready"},  64'(up_if.ready), 64'(erdy));
    endtask

    function automatic vec_t mk(bit fl, bit iv, logic [63:0] d, bit ordy,
                                bit ev, logic [63:0] ed, bit erdy);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.erdy = erdy;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        bit prev_ev;
        int exp_stall;
        int exp_flush;

        // Expected outputs are the state just after the clock edge that consumed the inputs
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(N, Y, 64'(k), Y, Y, 64'(k), Y));
        vecs.push_back(mk(N, N, 64'h0, Y, N, NOP,   Y));
        vecs.push_back(mk(N, Y, 64'hA, N, Y, 64'hA, Y));
        vecs.push_back(mk(N, Y, 64'hB, N, Y, 64'hA, N));
        vecs.push_back(mk(N, Y, 64'hC, N, Y, 64'hA, N));
        vecs.push_back(mk(N, Y, 64'hC, Y, Y, 64'hB, Y));
        vecs.push_back(mk(N, Y, 64'hC, N, Y, 64'hB, N));
        vecs.push_back(mk(N, N, 64'h0, Y, Y, 64'hC, Y));
        vecs.push_back(mk(N, N, 64'h0, Y, N, NOP,   Y));
        // Flush in TWO with a concurrent accept: 0xC must never surface
        vecs.push_back(mk(N, Y, 64'hA, N, Y, 64'hA, Y));
        vecs.push_back(mk(N, Y, 64'hB, N, Y, 64'hA, N));
        vecs.push_back(mk(Y, Y, 64'hC, N, N, NOP,   Y));
        vecs.push_back(mk(N, N, 64'h0, Y, N, NOP,   Y));
        vecs.push_back(mk(N, Y, 64'hD, N, Y, 64'hD, Y));
        vecs.push_back(mk(Y, Y, 64'hE, Y, N, NOP,   Y));
        vecs.push_back(mk(Y, N, 64'h0, Y, N, NOP,   Y));
        vecs.push_back(mk(N, Y, 64'h5, Y, Y, 64'h5, Y));
        vecs.push_back(mk(N, N, 64'h0, Y, N, NOP,   Y));

        drive(N, N, 64'h0, N);
        #12;
        chk_out("reset", N, NOP, Y);
        rst = 1'b0;

        prev_ev   = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            if (prev_ev && !vecs[i].ordy) exp_stall++;
            if (prev_ev && vecs[i].fl) exp_flush++;
            step();
            chk_out($sformatf("v%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].erdy);
            prev_ev = vecs[i].ev;
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("table stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        chk("table flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`endif

        // Async reset while holding two entries
        drive(N, Y, 64'hA, N); step();
        drive(N, Y, 64'hB, N); step();
        drive(N, N, 64'h0, N);
        chk_out("pre-reset TWO", Y, 64'hA, N);
        #2;
        rst = 1'b1;
        #1;
        chk_out("mid reset", N, NOP, Y);
`ifdef PIPE_STAGE_PERF_EN
        chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset flush_cnt", 64'(flush_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Hold a single entry stalled for 5 then 10 cycles
        drive(N, Y, 64'h7, N); step();
        drive(N, N, 64'h0, N);
        for (int k = 0; k < 5; k++) step();
        chk_out("stall5", Y, 64'h7, Y);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt after 5", 64'(stall_cnt), 64'd5);
`endif
        for (int k = 0; k < 5; k++) step();
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt after 10", 64'(stall_cnt), 64'd10);
        chk("stall_cnt2 saturated", 64'(stall_cnt2), 64'd3);
`endif
        drive(N, N, 64'h0, Y); step();
        chk_out("drain", N, NOP, Y);
        drive(Y, N, 64'h0, Y); step();
        drive(N, N, 64'h0, Y);
        chk_out("flush empty", N, NOP, Y);
`ifdef PIPE_STAGE_PERF_EN
        chk("flush_cnt empty flush", 64'(flush_cnt), 64'd0);
        chk("stall_cnt held", 64'(stall_cnt), 64'd10);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
